// File: rtl/ula_arbiter_if.sv
// ula_arbiter_if: request/result bus between two requesters, the arbiter and a ULA instance.
// slave  = arbiter side (takes req/a/b/sel and ULA result; drives gnt/done/res/flag, ULA inputs and busy)
// master = environment side (requesters plus the ULA)
interface ula_arbiter_if;
  logic       req0, req1;
  logic [3:0] a0, a1, b0, b1;
  logic [1:0] sel0, sel1;
  logic       gnt0, gnt1, done0, done1;
  logic [3:0] res0, res1;
  logic       flag0, flag1;
  logic [3:0] ula_a, ula_b;
  logic [1:0] ula_sel;
  logic [3:0] ula_resul;
  logic       ula_flag;
  logic       busy;
  modport slave (
    input  req0, req1, a0, a1, b0, b1, sel0, sel1, ula_resul, ula_flag,
    output gnt0, gnt1, done0, done1, res0, res1, flag0, flag1, ula_a, ula_b, ula_sel, busy
  );
  modport master (
    output req0, req1, a0, a1, b0, b1, sel0, sel1, ula_resul, ula_flag,
    input  gnt0, gnt1, done0, done1, res0, res1, flag0, flag1, ula_a, ula_b, ula_sel, busy
  );
endinterface

// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin two-port arbiter/sequencer in front of a shared 4-bit ULA.
// Ports: clk, rst (sync, active-high), bus (ula_arbiter_if.slave: requests, operands,
// gnt/done pulses, per-port res/flag, ULA a/b/sel out, ULA result in, busy).
// Build option: ULA_ARB_FIXED_PRIO_EN gives requester 0 fixed priority (no pointer).
module ula_arbiter (
  input logic         clk,
  input logic         rst,
  ula_arbiter_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;
  state_e     state_q, state_d;
  logic       any_req, start, busy, win, id_q;
  logic [3:0] op_a_q, op_b_q;
  logic [1:0] op_sel_q;
  logic       gnt0_q, gnt1_q, done0_q, done1_q;
  logic [3:0] res0_q, res1_q;
  logic       flag0_q, flag1_q;
  assign any_req = bus.req0 | bus.req1;
  assign start   = (state_q == IDLE) & any_req;
`ifdef ULA_ARB_FIXED_PRIO_EN
  assign win = ~bus.req0;
`else
  logic last_q;
  // win=1 selects requester 1; on contention serve whoever was not served last
  assign win = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      id_q     <= 1'b0;
      op_a_q   <= 4'd0;
      op_b_q   <= 4'd0;
      op_sel_q <= 2'd0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      res0_q   <= 4'd0;
      res1_q   <= 4'd0;
      flag0_q  <= 1'b0;
      flag1_q  <= 1'b0;
`ifndef ULA_ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt0_q  <= start & ~win;
      gnt1_q  <= start & win;
      done0_q <= busy & ~id_q;
      done1_q <= busy & id_q;
      if (start) begin
        id_q     <= win;
        op_a_q   <= win ? bus.a1 : bus.a0;
        op_b_q   <= win ? bus.b1 : bus.b0;
        op_sel_q <= win ? bus.sel1 : bus.sel0;
      end
      if (busy & ~id_q) begin
        res0_q  <= bus.ula_resul;
        flag0_q <= bus.ula_flag;
      end
      if (busy & id_q) begin
        res1_q  <= bus.ula_resul;
        flag1_q <= bus.ula_flag;
      end
`ifndef ULA_ARB_FIXED_PRIO_EN
      if (busy) last_q <= id_q;
`endif
    end
  end
  always_comb begin
    state_d = start ? EXEC : IDLE;
  end
  always_comb begin
    busy        = state_q == EXEC;
    bus.ula_a   = busy ? op_a_q : 4'd0;
    bus.ula_b   = busy ? op_b_q : 4'd0;
    bus.ula_sel = busy ? op_sel_q : 2'd0;
  end
  assign bus.busy  = busy;
  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.res0  = res0_q;
  assign bus.res1  = res1_q;
  assign bus.flag0 = flag0_q;
  assign bus.flag1 = flag1_q;
endmodule

// File: tb/tb_ula_arbiter.sv
// tb_ula_arbiter: directed vector bench for ula_arbiter with a behavioural ULA.
module tb_ula_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  ula_arbiter_if bus();
  ula_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  logic [4:0] u;
  always_comb begin
    u = (bus.ula_sel == 2'd0) ? {1'b0, bus.ula_a} + {1'b0, bus.ula_b} :
        (bus.ula_sel == 2'd1) ? {1'b0, bus.ula_a} - {1'b0, bus.ula_b} :
        (bus.ula_sel == 2'd2) ? {2'b00, bus.ula_a[3:1]} : {bus.ula_a, 1'b0};
  end
  assign bus.ula_resul = u[3:0];
  assign bus.ula_flag  = u[4];
  typedef struct {
    logic       p;
    logic [3:0] a, b;
    logic [1:0] sel;
    logic [3:0] res;
    logic       flag;
  } vec_t;
  vec_t v[8];
  int total = 0, bad = 0;
  logic [3:0] r0, r1;
  logic       f0, f1, fixed, p;
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask
  initial begin
`ifdef ULA_ARB_FIXED_PRIO_EN
    fixed = 1'b1;
`else
    fixed = 1'b0;
`endif
    v[0] = '{1'b0, 4'd5, 4'd3, 2'b00, 4'd8, 1'b0};
    v[1] = '{1'b1, 4'd9, 4'd8, 2'b00, 4'd1, 1'b1};
    v[2] = '{1'b1, 4'd3, 4'd5, 2'b01, 4'hE, 1'b1};
    v[3] = '{1'b0, 4'b1001, 4'd1, 2'b11, 4'b0010, 1'b1};
    v[4] = '{1'b0, 4'b1001, 4'd1, 2'b10, 4'b0100, 1'b0};
    v[5] = '{1'b1, 4'hF, 4'd1, 2'b00, 4'd0, 1'b1};
    v[6] = '{1'b0, 4'd2, 4'd3, 2'b01, 4'hF, 1'b1};
    v[7] = '{1'b1, 4'd8, 4'd0, 2'b10, 4'd4, 1'b0};
    rst = 1'b1;
    bus.req0 = 1'b1; bus.a0 = 4'd1; bus.b0 = 4'd1; bus.sel0 = 2'd0;
    bus.req1 = 1'b1; bus.a1 = 4'd7; bus.b1 = 4'd9; bus.sel1 = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {9'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.flag0, bus.flag1}, 16'd0);
    chk("rst_res", {8'd0, bus.res0, bus.res1}, 16'd0);
    chk("rst_ula", {6'd0, bus.ula_a, bus.ula_b, bus.ula_sel}, 16'd0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      p = fixed ? 1'b0 : 1'(k / 2 % 2);
      if (k % 2 == 0) begin
        chk("cont_gnt", {14'd0, bus.gnt1, bus.gnt0}, p ? 16'd2 : 16'd1);
        chk("cont_busy_done", {13'd0, bus.busy, bus.done1, bus.done0}, 16'h4);
      end else begin
        chk("cont_done", {14'd0, bus.done1, bus.done0}, p ? 16'd2 : 16'd1);
        chk("cont_res", p ? {11'd0, bus.flag1, bus.res1} : {11'd0, bus.flag0, bus.res0}, p ? 16'h10 : 16'h02);
        chk("cont_idle", {13'd0, bus.busy, bus.gnt1, bus.gnt0}, 16'd0);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    r0 = 4'd2; f0 = 1'b0; r1 = 4'd0; f1 = ~fixed;
    @(negedge clk);
    chk("no_req", {14'd0, bus.gnt1, bus.gnt0}, 16'd0);
    for (int i = 0; i < 8; i++) begin
      bus.a0 = 4'hA; bus.b0 = 4'h5; bus.sel0 = 2'd1;
      bus.a1 = 4'h6; bus.b1 = 4'hC; bus.sel1 = 2'd2;
      if (v[i].p) begin
        bus.req1 = 1'b1; bus.a1 = v[i].a; bus.b1 = v[i].b; bus.sel1 = v[i].sel;
      end else begin
        bus.req0 = 1'b1; bus.a0 = v[i].a; bus.b0 = v[i].b; bus.sel0 = v[i].sel;
      end
      @(negedge clk);
      chk("vec_gnt", {13'd0, bus.busy, bus.gnt1, bus.gnt0}, v[i].p ? 16'h6 : 16'h5);
      chk("vec_ula", {6'd0, bus.ula_a, bus.ula_b, bus.ula_sel}, {6'd0, v[i].a, v[i].b, v[i].sel});
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      @(negedge clk);
      if (v[i].p) begin r1 = v[i].res; f1 = v[i].flag; end
      else begin r0 = v[i].res; f0 = v[i].flag; end
      chk("vec_done", {12'd0, bus.busy, bus.gnt0, bus.done1, bus.done0}, v[i].p ? 16'd2 : 16'd1);
      chk("vec_res", {6'd0, bus.flag0, bus.res0, bus.flag1, bus.res1}, {6'd0, f0, r0, f1, r1});
    end
    bus.req0 = 1'b1; bus.a0 = 4'd5; bus.b0 = 4'd3; bus.sel0 = 2'd0;
    @(negedge clk);
    chk("mid_gnt", {14'd0, bus.busy, bus.gnt0}, 16'd3);
    rst = 1'b1; bus.req0 = 1'b0;
    @(negedge clk);
    chk("mid_ctl", {13'd0, bus.busy, bus.done1, bus.done0}, 16'd0);
    chk("mid_res", {6'd0, bus.flag0, bus.res0, bus.flag1, bus.res1}, 16'd0);
    rst = 1'b0;
    bus.req0 = 1'b1; bus.a0 = 4'd1; bus.b0 = 4'd1; bus.sel0 = 2'd0;
    bus.req1 = 1'b1; bus.a1 = 4'd2; bus.b1 = 4'd2; bus.sel1 = 2'd0;
    @(negedge clk);
    chk("post_gnt0", {14'd0, bus.gnt1, bus.gnt0}, 16'd1);
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("post_done0", {10'd0, bus.done1, bus.done0, bus.res0}, 16'h12);
    @(negedge clk);
    chk("post_gnt1", {14'd0, bus.gnt1, bus.gnt0}, 16'd2);
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("post_done1", {10'd0, bus.done1, bus.done0, bus.res1}, 16'h24);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
